// File: rtl/prince_pkg.sv
// prince_pkg: shared PRINCE constants, FSM state type and round primitives
// (S-layer, M'-layer, shift-rows) used by the iterative core.
package prince_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] STEP_MID  = 4'd6;
    localparam logic [3:0] STEP_LAST = 4'd12;

    localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;

    // Nibble i of the table holds S(i) / S^-1(i).
    localparam logic [63:0] SBOX     = 64'h4D5E087619CA23FB;
    localparam logic [63:0] SBOX_INV = 64'h1CE5046A98DF237B;

    function automatic logic [63:0] rc_of(input logic [3:0] i);
        logic [63:0] rc;
        case (i)
            4'd0:    rc = 64'h0000000000000000;
            4'd1:    rc = 64'h13198a2e03707344;
            4'd2:    rc = 64'ha4093822299f31d0;
            4'd3:    rc = 64'h082efa98ec4e6c89;
            4'd4:    rc = 64'h452821e638d01377;
            4'd5:    rc = 64'hbe5466cf34e90c6c;
            4'd6:    rc = 64'h7ef84f78fd955cb1;
            4'd7:    rc = 64'h85840851f1ac43aa;
            4'd8:    rc = 64'hc882d32f25323c54;
            4'd9:    rc = 64'h64a51195e0e3610d;
            4'd10:   rc = 64'hd3b5a399ca0c2399;
            4'd11:   rc = 64'hc0ac29b7c97c50dd;
            default: rc = 64'h0000000000000000;
        endcase
        return rc;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = SBOX[{x[4*i +: 4], 2'b00} +: 4];
        return y;
    endfunction

    function automatic logic [63:0] s_inv_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = SBOX_INV[{x[4*i +: 4], 2'b00} +: 4];
        return y;
    endfunction

    // 16x16 block of M': block (r,c) is diag M_k with k=(r+c+off)%4, where
    // M_k is the identity with its k-th diagonal entry cleared. Bit 15 is row 0.
    function automatic logic [15:0] m_hat(input logic [15:0] x, input logic [1:0] off);
        logic [15:0] y;
        logic [1:0]  sel;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sel = 2'(r + c) + off;
                for (int j = 0; j < 4; j++) begin
                    if (sel != 2'(j)) y[15 - 4*r - j] = y[15 - 4*r - j] ^ x[15 - 4*c - j];
                end
            end
        end
        return y;
    endfunction

    // M' = diag(M0^, M1^, M1^, M0^); an involution, so also its own inverse.
    function automatic logic [63:0] m_prime(input logic [63:0] x);
        return {m_hat(x[63:48], 2'd0), m_hat(x[47:32], 2'd1),
                m_hat(x[31:16], 2'd1), m_hat(x[15:0],  2'd0)};
    endfunction

    // Shift-rows on nibbles (nibble 0 is the most significant): out[i] = in[5i mod 16].
    function automatic logic [63:0] sr(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[63 - 4*i -: 4] = x[63 - 4*((5*i) % 16) -: 4];
        return y;
    endfunction

    function automatic logic [63:0] sr_inv(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[63 - 4*((5*i) % 16) -: 4] = x[63 - 4*i -: 4];
        return y;
    endfunction

endpackage

// File: rtl/prince_lane_step.sv
// prince_lane_step: combinational single-step PRINCE datapath for one 64-bit
// lane. Step 0 whitening + RC0, 1-5 forward rounds, 6 middle, 7-11 inverse
// rounds, 12 final key addition + output whitening.
module prince_lane_step
    import prince_pkg::*;
(
    input  logic [63:0] state,
    input  logic [3:0]  step,
    input  logic [63:0] kc,
    input  logic [63:0] kin,
    input  logic [63:0] kout,
    output logic [63:0] next
);

    logic [63:0] rk;

    // Select the round key for this step and apply the matching round shape.
    always_comb begin
        rk   = kc ^ rc_of((step <= STEP_MID) ? step : step - 4'd1);
        next = '0;
        if (step == 4'd0)
            next = state ^ kin ^ rk;
        else if (step < STEP_MID)
            next = sr(m_prime(s_layer(state))) ^ rk;
        else if (step == STEP_MID)
            next = s_inv_layer(m_prime(s_layer(state)));
        else if (step < STEP_LAST)
            next = s_inv_layer(m_prime(sr_inv(state ^ rk)));
        else
            next = state ^ rk ^ kout;
    end

endmodule

// File: rtl/prince_iter.sv
// prince_iter: iterative PRINCE encrypt/decrypt, one step per clock over 13
// steps, LANES independent 64-bit blocks in lockstep under one key.
// Optional feature: define PRINCE_ITER_STATS_EN to add the blk_cnt output
// (saturating count of completed output handshakes).
module prince_iter
    import prince_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                enc,
    input  logic [127:0]        key,
    input  logic [64*LANES-1:0] din,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [64*LANES-1:0] dout,
    output logic                busy
`ifdef PRINCE_ITER_STATS_EN
    ,
    output logic [31:0]         blk_cnt
`endif
);

    localparam int W = 64 * LANES;

    state_t       state_reg;
    logic [3:0]   step_reg;
    logic [W-1:0] data_reg;
    logic [W-1:0] data_next;
    logic [W-1:0] dout_reg;
    logic [63:0]  kin_reg, kout_reg, kc_reg;
    logic         out_valid_reg, busy_reg;

    logic [63:0]  k0, k1, k0_prime;
    logic [63:0]  kin_next, kout_next, kc_next;
    logic         accept;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign dout      = dout_reg;

    // Decryption reuses the encrypt datapath with swapped whitening keys and kc^ALPHA.
    assign k0        = key[127:64];
    assign k1        = key[63:0];
    assign k0_prime  = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};
    assign kin_next  = enc ? k0 : k0_prime;
    assign kout_next = enc ? k0_prime : k0;
    assign kc_next   = enc ? k1 : (k1 ^ ALPHA);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            prince_lane_step u_step (
                .state (data_reg[64*gi +: 64]),
                .step  (step_reg),
                .kc    (kc_reg),
                .kin   (kin_reg),
                .kout  (kout_reg),
                .next  (data_next[64*gi +: 64])
            );
        end
    endgenerate

    // Control FSM and datapath registers; an accept in DONE overrides the IDLE return.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            step_reg      <= 4'd0;
            data_reg      <= '0;
            dout_reg      <= '0;
            kin_reg       <= '0;
            kout_reg      <= '0;
            kc_reg        <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: ;
                RUN: begin
                    data_reg <= data_next;
                    if (step_reg == STEP_LAST) begin
                        state_reg     <= DONE;
                        step_reg      <= 4'd0;
                        dout_reg      <= data_next;
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end else begin
                        step_reg <= step_reg + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            if (accept) begin
                state_reg <= RUN;
                step_reg  <= 4'd0;
                busy_reg  <= 1'b1;
                data_reg  <= din;
                kin_reg   <= kin_next;
                kout_reg  <= kout_next;
                kc_reg    <= kc_next;
            end
        end
    end

`ifdef PRINCE_ITER_STATS_EN
    logic [31:0] blk_cnt_reg;
    assign blk_cnt = blk_cnt_reg;

    // Saturating count of output handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n)
            blk_cnt_reg <= 32'd0;
        else if (out_valid_reg && out_ready && (blk_cnt_reg != 32'hffffffff))
            blk_cnt_reg <= blk_cnt_reg + 32'd1;
    end
`endif

endmodule

// File: tb/tb_prince_iter.sv
// tb_prince_iter: scoreboard bench for prince_iter with LANES=2. Expected
// results are published PRINCE vectors pushed when a request is accepted and
// compared when the output handshake occurs. Works with or without
// PRINCE_ITER_STATS_EN defined.
module tb_prince_iter;

    localparam int LANES = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic                enc;
    logic [127:0]        key;
    logic [64*LANES-1:0] din;
    logic                out_valid;
    logic                out_ready;
    logic [64*LANES-1:0] dout;
    logic                busy;
`ifdef PRINCE_ITER_STATS_EN
    logic [31:0]         blk_cnt;
`endif

    prince_iter #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .enc       (enc),
        .key       (key),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
`ifdef PRINCE_ITER_STATS_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        tag;
        logic [127:0] exp;
        int           acc_cyc;
    } item_t;

    item_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    localparam logic [63:0] ONES = 64'hffffffffffffffff;
    localparam logic [63:0] K1T  = 64'hfedcba9876543210;
    localparam logic [63:0] PT   = 64'h0123456789abcdef;
    localparam logic [63:0] CT   = 64'hae25ad3ca8fa9ccf;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request (called at a falling edge), wait for acceptance, then scramble inputs.
    task automatic send(input string tag, input logic e, input logic [127:0] k,
                        input logic [127:0] d, input logic [127:0] exp);
        int    budget;
        item_t it;
        in_valid = 1'b1;
        enc      = e;
        key      = k;
        din      = d;
        #1;
        budget = 100;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            check_eq({tag, "_accept_timeout"}, 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            return;
        end
        it.tag     = tag;
        it.exp     = exp;
        it.acc_cyc = cyc + 1;
        sb_q.push_back(it);
        $display("send %s enc=%0b key=%h din=%h", tag, e, k, d);
        @(negedge clk);
        in_valid = 1'b0;
        enc      = 1'($urandom);
        key      = {$urandom, $urandom, $urandom, $urandom};
        din      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_drain(input string tag);
        int b;
        b = 200;
        while ((sb_q.size() != 0 || out_valid) && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (b == 0) check_eq({tag, "_drain_timeout"}, 128'(sb_q.size()), 128'(0));
    endtask

    // Monitor: latency check on out_valid rise, result check on output handshake.
    initial begin : monitor
        logic  prev_ov;
        item_t it;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (out_valid === 1'b1 && !prev_ov) begin
                if (sb_q.size() == 0)
                    check_eq("spurious_out_valid", 128'(out_valid), 128'(0));
                else
                    check_eq({sb_q[0].tag, "_latency"}, 128'(cyc), 128'(sb_q[0].acc_cyc + 13));
            end
            if (out_valid === 1'b1 && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_handshake", 128'(out_valid), 128'(0));
                end else begin
                    it = sb_q.pop_front();
                    $display("recv %s dout=%h exp=%h", it.tag, dout, it.exp);
                    check_eq({it.tag, "_dout"}, dout, it.exp);
                end
            end
            prev_ov = (out_valid === 1'b1);
        end
    end

    initial begin : driver
        int b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        enc       = 1'b1;
        key       = '0;
        din       = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_dout", dout, 128'(0));
`ifdef PRINCE_ITER_STATS_EN
        check_eq("rst_blk_cnt", 128'(blk_cnt), 128'(0));
`endif
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);

        // Known vectors, issued back to back with out_ready held high
        send("A_k0", 1'b1, {64'h0, 64'h0}, {ONES, 64'h0},
             {64'h604ae6ca03c20ada, 64'h818665aa0d02dfda});
        send("B_k0ones", 1'b1, {ONES, 64'h0}, {64'h0, 64'h0},
             {64'h9fb51935fc3df524, 64'h9fb51935fc3df524});
        send("C_k1ones", 1'b1, {64'h0, ONES}, {64'h0, 64'h0},
             {64'h78a54cbe737bb7ef, 64'h78a54cbe737bb7ef});
        send("D_dec", 1'b0, {64'h0, K1T}, {CT, CT}, {PT, PT});
        wait_drain("vectors");

        // Backpressure: result held for 5 cycles, then release with a new request
        out_ready = 1'b0;
        send("E_hold", 1'b1, {64'h0, 64'h0}, {64'h0, ONES},
             {64'h818665aa0d02dfda, 64'h604ae6ca03c20ada});
        b = 100;
        while (!out_valid && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (b == 0) check_eq("E_valid_timeout", 128'(out_valid), 128'(1));
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("hold_dout", dout, {64'h818665aa0d02dfda, 64'h604ae6ca03c20ada});
            check_eq("hold_in_ready", 128'(in_ready), 128'(0));
            check_eq("hold_out_valid", 128'(out_valid), 128'(1));
            @(negedge clk);
        end
        out_ready = 1'b1;
        send("F_b2b_enc", 1'b1, {64'h0, K1T}, {PT, PT}, {CT, CT});
        check_eq("b2b_busy", 128'(busy), 128'(1));
        check_eq("b2b_out_valid", 128'(out_valid), 128'(0));
        wait_drain("b2b");
`ifdef PRINCE_ITER_STATS_EN
        check_eq("blk_cnt_6", 128'(blk_cnt), 128'(6));
`endif

        // Reset in the middle of RUN at step 7
        send("G_aborted", 1'b1, {64'h0, 64'h0}, {64'h0, 64'h0},
             {64'h818665aa0d02dfda, 64'h818665aa0d02dfda});
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        check_eq("midrst_out_valid", 128'(out_valid), 128'(0));
        check_eq("midrst_busy", 128'(busy), 128'(0));
        check_eq("midrst_dout", dout, 128'(0));
`ifdef PRINCE_ITER_STATS_EN
        check_eq("midrst_blk_cnt", 128'(blk_cnt), 128'(0));
`endif
        rst_n = 1'b1;
        #1;
        check_eq("midrst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        send("H_after_rst", 1'b1, {ONES, 64'h0}, {64'h0, 64'h0},
             {64'h9fb51935fc3df524, 64'h9fb51935fc3df524});
        wait_drain("after_rst");
`ifdef PRINCE_ITER_STATS_EN
        check_eq("blk_cnt_1", 128'(blk_cnt), 128'(1));
`endif
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
